// File: rtl/axi4_wr_burst_to_ram.sv
// AXI4 write-only slave that turns one write burst at a time into direct writes
// on the write port of a dual-port RAM, then returns a single B response.
module axi4_wr_burst_to_ram #(
  parameter int unsigned ASIZE  = 32,
  parameter int unsigned DSIZE  = 32,
  parameter int unsigned IDSIZE = 4,
  parameter int unsigned RSIZE  = ASIZE - $clog2(DSIZE / 8)
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  // AW channel
  input  logic [IDSIZE-1:0]    s_awid,
  input  logic [ASIZE-1:0]     s_awaddr,
  input  logic [7:0]           s_awlen,
  input  logic [2:0]           s_awsize,
  input  logic [1:0]           s_awburst,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  // W channel
  input  logic [DSIZE-1:0]     s_wdata,
  input  logic [DSIZE/8-1:0]   s_wstrb,
  input  logic                 s_wlast,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  // B channel
  output logic [IDSIZE-1:0]    s_bid,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  // RAM write port
  output logic                 ram_en,
  output logic [DSIZE/8-1:0]   ram_we,
  output logic [RSIZE-1:0]     ram_addr,
  output logic [DSIZE-1:0]     ram_din
);

  localparam int unsigned    LOG2B    = $clog2(DSIZE / 8);
  localparam logic [2:0]     MaxSize  = 3'(LOG2B);
  localparam logic [ASIZE-1:0] AddrOne = {{(ASIZE-1){1'b0}}, 1'b1};

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e            state_q, state_d;
  logic [IDSIZE-1:0] id_q;
  logic [ASIZE-1:0]  cur_addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_cnt_q;
  logic              burst_err_q;
  logic              last_err_q;

  logic              aw_hs;
  logic              beat;
  logic              beat_is_final;
  logic              last_mismatch;
  logic              aw_burst_err;
  logic              wrap_len_ok;
  logic [ASIZE-1:0]  addr_incr;
  logic [ASIZE-1:0]  addr_sum;
  logic [ASIZE-1:0]  wrap_bytes;
  logic [ASIZE-1:0]  wrap_mask;
  logic [ASIZE-1:0]  addr_next;

  // FSM next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    aw_hs     = 1'b0;
    beat      = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_awready = 1'b1;
        aw_hs     = s_awvalid;
        if (s_awvalid) begin
          state_d = StData;
        end
      end
      StData: begin
        s_wready = 1'b1;
        beat     = s_wvalid;
        if (s_wvalid && beat_is_final) begin
          state_d = StResp;
        end
      end
      StResp: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The burst ends on whichever comes first: the counted last beat or WLAST.
  assign beat_is_final = (beat_cnt_q == len_q) || s_wlast;
  assign last_mismatch = s_wlast ^ (beat_cnt_q == len_q);

  // Burst legality is decided once, from the AW payload.
  always_comb begin
    wrap_len_ok  = (s_awlen == 8'd1) || (s_awlen == 8'd3) ||
                   (s_awlen == 8'd7) || (s_awlen == 8'd15);
    aw_burst_err = (s_awburst == 2'b11) ||
                   ((s_awburst == BurstWrap) && !wrap_len_ok) ||
                   (s_awsize > MaxSize);
  end

  // Next beat address
  always_comb begin
    addr_incr  = AddrOne << size_q;
    addr_sum   = cur_addr_q + addr_incr;
    wrap_bytes = ({{(ASIZE-8){1'b0}}, len_q} + AddrOne) << size_q;
    wrap_mask  = wrap_bytes - AddrOne;
    addr_next  = cur_addr_q;
    unique case (burst_q)
      BurstFixed: addr_next = cur_addr_q;
      BurstIncr:  addr_next = addr_sum;
      BurstWrap:  addr_next = (cur_addr_q & ~wrap_mask) | (addr_sum & wrap_mask);
      default:    addr_next = cur_addr_q;
    endcase
  end

  // RAM port is driven straight from the W beat so the write lands on the handshake edge.
  always_comb begin
    ram_en   = beat;
    ram_we   = (beat && !burst_err_q) ? s_wstrb : '0;
    ram_addr = cur_addr_q[ASIZE-1:LOG2B];
    ram_din  = s_wdata;
  end

  assign s_bid   = id_q;
  assign s_bresp = (burst_err_q || last_err_q) ? RespSlvErr : RespOkay;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q     <= StIdle;
      id_q        <= '0;
      cur_addr_q  <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
      last_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q        <= s_awid;
        cur_addr_q  <= s_awaddr;
        len_q       <= s_awlen;
        size_q      <= s_awsize;
        burst_q     <= s_awburst;
        beat_cnt_q  <= '0;
        burst_err_q <= aw_burst_err;
        last_err_q  <= 1'b0;
      end
      if (beat) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        cur_addr_q <= addr_next;
        if (last_mismatch) begin
          last_err_q <= 1'b1;
        end
      end
    end
  end

  // Only one channel may be open at a time.
  a_one_channel: assert property (@(posedge axi_aclk)
    $onehot0({s_awready, s_wready, s_bvalid}));
  a_ram_only_in_data: assert property (@(posedge axi_aclk)
    ram_en |-> s_wready);

endmodule

// File: tb/tb_axi4_wr_burst_to_ram.sv
// Directed bench for axi4_wr_burst_to_ram: one task per scenario, inline checks.
module tb_axi4_wr_burst_to_ram;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_wr_burst_to_ram dut (
    .axi_aclk    (clk),
    .axi_aresetn (rstn),
    .s_awid      (s_awid),
    .s_awaddr    (s_awaddr),
    .s_awlen     (s_awlen),
    .s_awsize    (s_awsize),
    .s_awburst   (s_awburst),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_wlast     (s_wlast),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_bid       (s_bid),
    .s_bresp     (s_bresp),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din)
  );

  // All tasks start and end on a falling edge; inputs change there, outputs are read #1 later.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    #1;
    checks++;
    if (s_awready !== 1'b1 || s_wready !== 1'b0) begin
      errors++;
      $display("FAIL aw_accept: awready=%b wready=%b required awready=1 wready=0",
               s_awready, s_wready);
    end
    @(negedge clk);
    s_awvalid = 1'b0;
  endtask

  task automatic send_beat(input string nm, input logic [31:0] d, input logic [3:0] st,
                           input logic last, input logic chk_addr, input logic [29:0] ea,
                           input logic [3:0] ewe);
    s_wdata = d; s_wstrb = st; s_wlast = last; s_wvalid = 1'b1;
    #1;
    checks++;
    if (ram_en !== 1'b1 || s_wready !== 1'b1 || ram_we !== ewe || ram_din !== d ||
        s_bvalid !== 1'b0 || (chk_addr && ram_addr !== ea)) begin
      errors++;
      $display("FAIL %s: en=%b wready=%b we=%h din=%h bvalid=%b addr=%h required en=1 wready=1 we=%h din=%h bvalid=0 addr=%h",
               nm, ram_en, s_wready, ram_we, ram_din, s_bvalid, ram_addr, ewe, d, ea);
    end
    @(negedge clk);
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic take_resp(input string nm, input logic [1:0] eresp, input logic [3:0] eid);
    #1;
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== eresp || s_bid !== eid || s_awready !== 1'b0 ||
        s_wready !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp: bvalid=%b bresp=%b bid=%h awready=%b wready=%b en=%b required bvalid=1 bresp=%b bid=%h awready=0 wready=0 en=0",
               nm, s_bvalid, s_bresp, s_bid, s_awready, s_wready, ram_en, eresp, eid);
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    checks++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: bvalid=%b awready=%b required bvalid=0 awready=1",
               nm, s_bvalid, s_awready);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_wlast = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_wdata = '0; s_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (s_awready !== 1'b1 || s_wready !== 1'b0 || s_bvalid !== 1'b0 || s_bresp !== 2'b00 ||
        s_bid !== 4'h0 || ram_en !== 1'b0 || ram_we !== 4'h0) begin
      errors++;
      $display("FAIL reset: awready=%b wready=%b bvalid=%b bresp=%b bid=%h en=%b we=%h required 1 0 0 00 0 0 0",
               s_awready, s_wready, s_bvalid, s_bresp, s_bid, ram_en, ram_we);
    end
    @(negedge clk);
  endtask

  task automatic test_incr();
    send_aw(4'h3, 32'h100, 8'd3, 3'd2, 2'b01);
    send_beat("incr_b0", 32'hD000_0000, 4'hF, 1'b0, 1'b1, 30'h40, 4'hF);
    send_beat("incr_b1", 32'hD111_1111, 4'h3, 1'b0, 1'b1, 30'h41, 4'h3);
    send_beat("incr_b2", 32'hD222_2222, 4'hC, 1'b0, 1'b1, 30'h42, 4'hC);
    send_beat("incr_b3", 32'hD333_3333, 4'h5, 1'b1, 1'b1, 30'h43, 4'h5);
    take_resp("incr", 2'b00, 4'h3);
  endtask

  task automatic test_wrap();
    send_aw(4'h5, 32'h18, 8'd3, 3'd2, 2'b10);
    send_beat("wrap_b0", 32'hA0, 4'hF, 1'b0, 1'b1, 30'h06, 4'hF);
    send_beat("wrap_b1", 32'hA1, 4'hF, 1'b0, 1'b1, 30'h07, 4'hF);
    send_beat("wrap_b2", 32'hA2, 4'hF, 1'b0, 1'b1, 30'h04, 4'hF);
    send_beat("wrap_b3", 32'hA3, 4'hF, 1'b1, 1'b1, 30'h05, 4'hF);
    take_resp("wrap", 2'b00, 4'h5);
  endtask

  task automatic test_fixed();
    send_aw(4'h7, 32'h20, 8'd2, 3'd2, 2'b00);
    send_beat("fixed_b0", 32'hF0, 4'hF, 1'b0, 1'b1, 30'h08, 4'hF);
    send_beat("fixed_b1", 32'hF1, 4'h1, 1'b0, 1'b1, 30'h08, 4'h1);
    send_beat("fixed_b2", 32'hF2, 4'h8, 1'b1, 1'b1, 30'h08, 4'h8);
    take_resp("fixed", 2'b00, 4'h7);
  endtask

  task automatic test_wlast_errors();
    // Early WLAST on beat 2 of a 4-beat burst
    send_aw(4'h2, 32'h200, 8'd3, 3'd2, 2'b01);
    send_beat("early_b0", 32'hE0, 4'hF, 1'b0, 1'b1, 30'h80, 4'hF);
    send_beat("early_b1", 32'hE1, 4'hF, 1'b1, 1'b1, 30'h81, 4'hF);
    take_resp("early", 2'b10, 4'h2);
    // WLAST missing on the final counted beat
    send_aw(4'h4, 32'h300, 8'd1, 3'd2, 2'b01);
    send_beat("nolast_b0", 32'hC0, 4'hF, 1'b0, 1'b1, 30'hC0, 4'hF);
    send_beat("nolast_b1", 32'hC1, 4'hF, 1'b0, 1'b1, 30'hC1, 4'hF);
    take_resp("nolast", 2'b10, 4'h4);
  endtask

  task automatic test_bad_burst();
    send_aw(4'h9, 32'h40, 8'd1, 3'd2, 2'b11);
    send_beat("rsvd_b0", 32'hB0, 4'hF, 1'b0, 1'b0, 30'h0, 4'h0);
    send_beat("rsvd_b1", 32'hB1, 4'hF, 1'b1, 1'b0, 30'h0, 4'h0);
    take_resp("rsvd", 2'b10, 4'h9);
    // WRAP with illegal length
    send_aw(4'hA, 32'h40, 8'd2, 3'd2, 2'b10);
    send_beat("wraplen_b0", 32'hB2, 4'hF, 1'b0, 1'b0, 30'h0, 4'h0);
    send_beat("wraplen_b1", 32'hB3, 4'hF, 1'b0, 1'b0, 30'h0, 4'h0);
    send_beat("wraplen_b2", 32'hB4, 4'hF, 1'b1, 1'b0, 30'h0, 4'h0);
    take_resp("wraplen", 2'b10, 4'hA);
  endtask

  task automatic test_bready_stall();
    send_aw(4'hB, 32'h4, 8'd0, 3'd2, 2'b01);
    send_beat("stall_b0", 32'h55, 4'hF, 1'b1, 1'b1, 30'h1, 4'hF);
    // A W beat offered during RESP must be held off, not written.
    s_wvalid = 1'b1; s_wlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (s_bvalid !== 1'b1 || s_bid !== 4'hB || s_bresp !== 2'b00 || s_awready !== 1'b0 ||
          s_wready !== 1'b0 || ram_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_cyc%0d: bvalid=%b bid=%h bresp=%b awready=%b wready=%b en=%b required 1 b 00 0 0 0",
                 i, s_bvalid, s_bid, s_bresp, s_awready, s_wready, ram_en);
      end
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    take_resp("stall", 2'b00, 4'hB);
  endtask

  task automatic test_reset_mid_burst();
    send_aw(4'hC, 32'h400, 8'd3, 3'd2, 2'b01);
    send_beat("rstmid_b0", 32'h11, 4'hF, 1'b0, 1'b1, 30'h100, 4'hF);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    // Leftover beats arriving after reset must not reach the RAM.
    s_wvalid = 1'b1; s_wdata = 32'h22; s_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ram_en !== 1'b0 || ram_we !== 4'h0 || s_bvalid !== 1'b0 || s_awready !== 1'b1 ||
          s_wready !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_cyc%0d: en=%b we=%h bvalid=%b awready=%b wready=%b required 0 0 0 1 0",
                 i, ram_en, ram_we, s_bvalid, s_awready, s_wready);
      end
      @(negedge clk);
    end
    s_wvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    send_aw(4'h1, 32'h8, 8'd0, 3'd2, 2'b01);
    send_beat("b2b0_b0", 32'h77, 4'hF, 1'b1, 1'b1, 30'h2, 4'hF);
    take_resp("b2b0", 2'b00, 4'h1);
    send_aw(4'hE, 32'hC, 8'd0, 3'd2, 2'b01);
    send_beat("b2b1_b0", 32'h88, 4'h2, 1'b1, 1'b1, 30'h3, 4'h2);
    take_resp("b2b1", 2'b00, 4'hE);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_wlast_errors();
    test_bad_burst();
    test_bready_stall();
    test_reset_mid_burst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_wr_burst_to_ram.md
AXI4_WR_BURST_TO_RAM -- requirements
Module: axi4_wr_burst_to_ram

Interface
REQ-001 SHALL have parameter ASIZE, default 32, byte-address width.
REQ-002 SHALL have parameter DSIZE, default 32, data width in bits (power of two, 8..1024).
REQ-003 SHALL have parameter IDSIZE, default 4, AXI ID width.
REQ-004 SHALL have parameter RSIZE, default ASIZE-log2(DSIZE/8), RAM word-address width.
REQ-005 SHALL have port axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port axi_aresetn  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports s_awid/s_awaddr/s_awlen/s_awsize/s_awburst  in  IDSIZE/ASIZE/8/3/2  AW payload.
REQ-008 SHALL have ports s_awvalid in 1, s_awready out 1  AW handshake.
REQ-009 SHALL have ports s_wdata in DSIZE, s_wstrb in DSIZE/8, s_wlast in 1, s_wvalid in 1, s_wready out 1  W channel.
REQ-010 SHALL have ports s_bid out IDSIZE, s_bresp out 2, s_bvalid out 1, s_bready in 1  B channel.
REQ-011 SHALL have ports ram_en out 1, ram_we out DSIZE/8, ram_addr out RSIZE, ram_din out DSIZE  write port of the dual-port RAM cache.

Function
REQ-012 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE; one burst outstanding.
REQ-013 IDLE: s_awready=1; on s_awvalid&&s_awready latch id, addr, len, size, burst; beat_cnt<=0; go DATA next cycle.
REQ-014 DATA: s_wready=1, s_awready=0; each s_wvalid&&s_wready is one beat.
REQ-015 Per beat, combinationally: ram_en=1, ram_we=s_wstrb (0 if burst error flagged), ram_addr=cur_addr[ASIZE-1:log2(DSIZE/8)], ram_din=s_wdata; outside beats ram_en=0, ram_we=0.
REQ-016 Address update after each beat: FIXED(00) unchanged; INCR(01) cur_addr+2^size, wraps mod 2^ASIZE; WRAP(10) cur_addr+2^size within boundary of (len+1)*2^size bytes aligned to that size, wrapping to lower boundary.
REQ-017 WRAP with len not in {1,3,7,15}, burst=11, or 2^size>DSIZE/8 SHALL flag error: beats consumed, ram_we=0, bresp=SLVERR(10).
REQ-018 Burst terminates on beat with beat_cnt==len OR s_wlast=1, whichever first; go RESP next cycle.
REQ-019 s_wlast mismatch (early, or absent on beat len) SHALL set bresp=SLVERR; beats written normally otherwise.
REQ-020 RESP: s_bvalid=1, s_bid=latched id, s_bresp=00 unless error; hold until s_bready; s_awready=0, s_wready=0.
REQ-021 Latency: s_bvalid asserts exactly 1 cycle after last W handshake; IDLE re-entered cycle after B handshake (min 3 cycles per single-beat burst).
REQ-022 beat_cnt SHALL be 8 bits, saturates not required (terminates at len).
REQ-023 W beats presented in IDLE/RESP SHALL stall (s_wready=0), never dropped.

Reset
REQ-024 On axi_aresetn=0 at rising edge: state=IDLE, s_bvalid=0, s_bresp=00, s_bid=0, beat_cnt=0, error flags=0; s_awready=1, s_wready=0, ram_en=0, ram_we=0 following reset.
REQ-025 Reset mid-burst or mid-RESP SHALL abandon transaction with no further RAM write and no B response.

Verification
REQ-026 INCR: awaddr=0x100, len=3, size=2, 4 beats D0..D3 wlast on 4th -> ram_addr 0x40,0x41,0x42,0x43, we=wstrb, bresp=00 one cycle later.
REQ-027 WRAP: awaddr=0x18, len=3, size=2 -> ram_addr 0x06,0x07,0x04,0x05, bresp=00.
REQ-028 FIXED: awaddr=0x20, len=2 -> three writes to ram_addr 0x08; early wlast on beat 2 of len=3 INCR -> 2 writes, bresp=10.
REQ-029 burst=11, len=1 -> 2 beats accepted, ram_we=0 both, bresp=10, bid=awid.
REQ-030 s_bready held low 5 cycles -> s_bvalid/bid/bresp stable, s_awready=0 throughout; reset asserted in DATA after beat 1 -> no more ram_en, no s_bvalid, s_awready=1 after reset.
